// File: rtl/fod_phase_ctrl.sv
// ---------------------------------------------------------------------------
// fod_phase_ctrl
//   Phase-select sequencer for the fractional output divider. It runs in the
//   FOD output clock domain. On every output edge it picks which of the 8
//   interleaved AUXPLL phases (Tvco/8 apart) fires the next edge. It also
//   picks how many whole VCO periods to skip before that phase. The fractional
//   control word is accumulated first-order, so the long-run output period is
//   fcw * Tvco/8. New words pass through a shadow register and take effect
//   only at edge boundaries.
//
// Ports
//   clk        FOD output clock, rising edge
//   rstn       asynchronous active-low reset
//   en         run request
//   cfg_fcw    new control word {int[INT_W], frac[FRAC_W]}
//   cfg_vld    cfg_fcw valid
//   cfg_rdy    word is accepted this cycle when cfg_vld is high
//   cfg_err    one-cycle pulse after an illegal word (int < MIN_STEP) is dropped
//   phase_sel  binary index of the FMP phase for the next edge
//   phase_oh   one-hot copy of phase_sel, all-zero while out_vld is low
//   div_cnt    whole VCO periods to skip before the selected phase
//   out_vld    phase_sel / phase_oh / div_cnt are meaningful
// ---------------------------------------------------------------------------
module fod_phase_ctrl #(
   parameter int unsigned INT_W    = 8,
   parameter int unsigned FRAC_W   = 16,
   parameter int unsigned MIN_STEP = 4
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    en,
   input  logic [INT_W+FRAC_W-1:0] cfg_fcw,
   input  logic                    cfg_vld,
   output logic                    cfg_rdy,
   output logic                    cfg_err,
   output logic [2:0]              phase_sel,
   output logic [7:0]              phase_oh,
   output logic [INT_W-3:0]        div_cnt,
   output logic                    out_vld
);

   localparam int unsigned FCW_W = INT_W + FRAC_W;
   // The pointer plus the largest step (2^INT_W) still fits in INT_W+1 bits.
   localparam int unsigned NXT_W = INT_W + 1;
   localparam logic [FCW_W-1:0] FCW_RST = {INT_W'(MIN_STEP), {FRAC_W{1'b0}}};

   typedef enum logic [1:0] {
      IDLE,
      ARM,
      RUN
   } state_e;

   state_e              state_q, state_d;
   logic [FCW_W-1:0]    fcw_act_q, fcw_act_d;
   logic [FCW_W-1:0]    fcw_shd_q, fcw_shd_d;
   logic                shd_pend_q, shd_pend_d;
   logic [FRAC_W-1:0]   acc_q, acc_d;
   logic [2:0]          ptr_q, ptr_d;
   logic [2:0]          phase_sel_q, phase_sel_d;
   logic [INT_W-3:0]    div_cnt_q, div_cnt_d;
   logic                out_vld_q, out_vld_d;
   logic                cfg_err_q, cfg_err_d;

   logic                apply;
   logic                xfer;
   logic                legal;
   logic [FCW_W-1:0]    fcw_use;
   logic [FRAC_W:0]     sum;
   logic [NXT_W-1:0]    steps;
   logic [NXT_W-1:0]    nxt;

   // A pending shadow word is applied on any ARM or RUN cycle. That cycle
   // already computes with the new word, so the shadow slot is free again at
   // once.
   always_comb begin
      apply   = shd_pend_q && (state_q != IDLE);
      cfg_rdy = !shd_pend_q || apply;
      xfer    = cfg_vld && cfg_rdy;
      legal   = cfg_fcw[FCW_W-1:FRAC_W] >= INT_W'(MIN_STEP);
      fcw_use = apply ? fcw_shd_q : fcw_act_q;
      sum     = {1'b0, acc_q} + {1'b0, fcw_use[FRAC_W-1:0]};
      steps   = NXT_W'(fcw_use[FCW_W-1:FRAC_W]) + NXT_W'(sum[FRAC_W]);
      nxt     = NXT_W'(ptr_q) + steps;
   end

   always_comb begin
      state_d     = state_q;
      fcw_act_d   = fcw_act_q;
      fcw_shd_d   = fcw_shd_q;
      shd_pend_d  = shd_pend_q;
      acc_d       = acc_q;
      ptr_d       = ptr_q;
      phase_sel_d = phase_sel_q;
      div_cnt_d   = div_cnt_q;
      out_vld_d   = 1'b0;
      cfg_err_d   = xfer && !legal;

      if (apply) begin
         fcw_act_d  = fcw_shd_q;
         shd_pend_d = 1'b0;
      end
      // A new word may land in the same cycle that the old shadow is applied.
      if (xfer && legal) begin
         fcw_shd_d  = cfg_fcw;
         shd_pend_d = 1'b1;
      end

      unique case (state_q)
         IDLE: begin
            if (en) state_d = ARM;
         end
         ARM: begin
            acc_d   = '0;
            ptr_d   = '0;
            state_d = RUN;
         end
         RUN: begin
            acc_d       = sum[FRAC_W-1:0];
            ptr_d       = nxt[2:0];
            phase_sel_d = nxt[2:0];
            div_cnt_d   = nxt[NXT_W-1:3];
            out_vld_d   = 1'b1;
            if (!en) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= IDLE;
         fcw_act_q   <= FCW_RST;
         fcw_shd_q   <= '0;
         shd_pend_q  <= 1'b0;
         acc_q       <= '0;
         ptr_q       <= '0;
         phase_sel_q <= '0;
         div_cnt_q   <= '0;
         out_vld_q   <= 1'b0;
         cfg_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         fcw_act_q   <= fcw_act_d;
         fcw_shd_q   <= fcw_shd_d;
         shd_pend_q  <= shd_pend_d;
         acc_q       <= acc_d;
         ptr_q       <= ptr_d;
         phase_sel_q <= phase_sel_d;
         div_cnt_q   <= div_cnt_d;
         out_vld_q   <= out_vld_d;
         cfg_err_q   <= cfg_err_d;
      end
   end

   always_comb begin
      phase_oh = '0;
      if (out_vld_q) phase_oh[phase_sel_q] = 1'b1;
   end

   assign phase_sel = phase_sel_q;
   assign div_cnt   = div_cnt_q;
   assign out_vld   = out_vld_q;
   assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_fod_phase_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fod_phase_ctrl
//   Self-checking bench for fod_phase_ctrl: a directed vector table, a few
//   hand-written multi-cycle sequences, and a randomized run checked against
//   a position-based reference model. The model tracks the absolute phase
//   position in units of 2^-FRAC_W phase steps.
// ---------------------------------------------------------------------------
module tb_fod_phase_ctrl;

   localparam int INT_W    = 8;
   localparam int FRAC_W   = 16;
   localparam int MIN_STEP = 4;
   localparam int FCW_W    = INT_W + FRAC_W;

   logic             clk = 1'b0;
   logic             rstn;
   logic             en;
   logic [FCW_W-1:0] cfg_fcw;
   logic             cfg_vld;
   logic             cfg_rdy;
   logic             cfg_err;
   logic [2:0]       phase_sel;
   logic [7:0]       phase_oh;
   logic [INT_W-3:0] div_cnt;
   logic             out_vld;

   int checks   = 0;
   int failures = 0;

   fod_phase_ctrl #(.INT_W(INT_W), .FRAC_W(FRAC_W), .MIN_STEP(MIN_STEP)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .en        (en),
      .cfg_fcw   (cfg_fcw),
      .cfg_vld   (cfg_vld),
      .cfg_rdy   (cfg_rdy),
      .cfg_err   (cfg_err),
      .phase_sel (phase_sel),
      .phase_oh  (phase_oh),
      .div_cnt   (div_cnt),
      .out_vld   (out_vld)
   );

   always #5 clk = ~clk;

   function automatic logic [FCW_W-1:0] mk(input int unsigned ip, input int unsigned fp);
      logic [FCW_W-1:0] w;
      w = {INT_W'(ip), FRAC_W'(fp)};
      return w;
   endfunction

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic e, input logic v, input logic [FCW_W-1:0] w);
      en      = e;
      cfg_vld = v;
      cfg_fcw = w;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input int s, input int d);
      chk({tag, "_vld"}, out_vld, 1);
      chk({tag, "_sel"}, phase_sel, s);
      chk({tag, "_div"}, div_cnt, d);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_rdy"}, cfg_rdy, 1);
      chk({tag, "_err"}, cfg_err, 0);
      chk({tag, "_sel"}, phase_sel, 0);
      chk({tag, "_oh"}, phase_oh, 0);
      chk({tag, "_div"}, div_cnt, 0);
      chk({tag, "_vld"}, out_vld, 0);
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic             en;
      logic             vld;
      logic [FCW_W-1:0] fcw;
      logic             e_vld;
      int               e_sel;
      int               e_div;
      logic             e_rdy;
      logic             e_err;
   } vec_t;

   vec_t tbl[16];

   function automatic vec_t v(input logic e, input logic vl, input logic [FCW_W-1:0] w,
                              input logic ev, input int es, input int ed,
                              input logic er, input logic ee);
      vec_t r;
      r.en = e; r.vld = vl; r.fcw = w;
      r.e_vld = ev; r.e_sel = es; r.e_div = ed; r.e_rdy = er; r.e_err = ee;
      return r;
   endfunction

   // ---------------- reference model ----------------
   int               m_mode;   // 0 idle, 1 arming, 2 running
   logic [FCW_W-1:0] m_act;
   logic [FCW_W-1:0] m_shd[$];
   longint           m_pos;    // absolute phase position, FRAC_W fractional bits
   logic             m_vld;
   logic             m_err;
   int               m_sel;
   int               m_div;

   task automatic model_reset();
      m_mode = 0;
      m_act  = mk(MIN_STEP, 0);
      m_shd.delete();
      m_pos  = 0;
      m_vld  = 1'b0;
      m_err  = 1'b0;
      m_sel  = 0;
      m_div  = 0;
   endtask

   function automatic logic model_rdy();
      return (m_shd.size() == 0) || (m_mode != 0);
   endfunction

   task automatic model_step(input logic e, input logic vl, input logic [FCW_W-1:0] w);
      logic             ap;
      logic             xf;
      logic [FCW_W-1:0] word;
      longint           p0;
      longint           p1;
      ap    = (m_shd.size() != 0) && (m_mode != 0);
      xf    = vl && model_rdy();
      word  = ap ? m_shd[0] : m_act;
      m_err = xf && (int'(w[FCW_W-1:FRAC_W]) < MIN_STEP);
      m_vld = 1'b0;
      case (m_mode)
         0: if (e) m_mode = 1;
         1: begin
            m_pos  = 0;
            m_mode = 2;
         end
         default: begin
            p0    = m_pos >>> FRAC_W;
            m_pos = m_pos + longint'(word);
            p1    = m_pos >>> FRAC_W;
            m_sel = int'(p1 % 8);
            m_div = int'(p1 / 8 - p0 / 8);
            m_vld = 1'b1;
            if (!e) m_mode = 0;
         end
      endcase
      if (ap) begin
         m_act = word;
         void'(m_shd.pop_front());
      end
      if (xf && !m_err) m_shd.push_back(w);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      longint sum_steps;
      int     prev;
      int     st;
      int     bad_vld;
      int     bad_step;
      logic             r_en;
      logic             r_vld;
      logic [FCW_W-1:0] r_fcw;
      int               r;

      rstn = 1'b0;
      drive(1'b0, 1'b0, '0);
      #12;
      chk_reset_vals("reset");
      rstn = 1'b1;

      // rows: en, vld, fcw | exp out_vld, sel, div, rdy, err
      tbl[0]  = v(1, 1, mk(10, 0),      0, 0, 0, 0, 0);
      tbl[1]  = v(1, 0, '0,             0, 0, 0, 1, 0);
      tbl[2]  = v(1, 0, '0,             0, 0, 0, 1, 0);
      tbl[3]  = v(1, 0, '0,             1, 2, 1, 1, 0);
      tbl[4]  = v(1, 0, '0,             1, 4, 1, 1, 0);
      tbl[5]  = v(1, 0, '0,             1, 6, 1, 1, 0);
      tbl[6]  = v(1, 0, '0,             1, 0, 2, 1, 0);
      tbl[7]  = v(0, 1, mk(10, 16'h8000), 1, 2, 1, 0, 0);
      tbl[8]  = v(1, 0, '0,             0, 0, 0, 1, 0);
      tbl[9]  = v(1, 0, '0,             0, 0, 0, 1, 0);
      tbl[10] = v(1, 0, '0,             1, 2, 1, 1, 0);
      tbl[11] = v(1, 0, '0,             1, 5, 1, 1, 0);
      tbl[12] = v(1, 0, '0,             1, 7, 1, 1, 0);
      tbl[13] = v(1, 0, '0,             1, 2, 2, 1, 0);
      tbl[14] = v(1, 1, mk(3, 0),       1, 4, 1, 1, 1);
      tbl[15] = v(1, 0, '0,             1, 7, 1, 1, 0);
      // Row 0 loads 10.0 while idle; en itself rises at row 1.
      tbl[0].en = 1'b0;

      for (int i = 0; i < 16; i++) begin
         drive(tbl[i].en, tbl[i].vld, tbl[i].fcw);
         tick();
         chk($sformatf("tbl%0d_vld", i), out_vld, tbl[i].e_vld);
         chk($sformatf("tbl%0d_rdy", i), cfg_rdy, tbl[i].e_rdy);
         chk($sformatf("tbl%0d_err", i), cfg_err, tbl[i].e_err);
         chk($sformatf("tbl%0d_oh", i), phase_oh,
             tbl[i].e_vld ? (8'h1 << tbl[i].e_sel) : 8'h0);
         if (tbl[i].e_vld) begin
            chk($sformatf("tbl%0d_sel", i), phase_sel, tbl[i].e_sel);
            chk($sformatf("tbl%0d_div", i), div_cnt, tbl[i].e_div);
         end
      end

      // Back-to-back 9.0 then 11.0 while running 10.5 from ptr=7, acc=0.
      drive(1, 1, mk(9, 0));
      tick();
      chk_out("b2b_a", 1, 2);
      chk("b2b_a_rdy", cfg_rdy, 1);
      drive(1, 1, mk(11, 0));
      tick();
      chk_out("b2b_b", 2, 1);
      chk("b2b_b_rdy", cfg_rdy, 1);
      drive(1, 0, '0);
      tick();
      chk_out("b2b_c", 5, 1);
      tick();
      chk_out("b2b_d", 0, 2);

      // Reset mid-RUN while a 20.0 word sits in the shadow.
      drive(1, 1, mk(20, 0));
      tick();
      chk_out("prerst", 3, 1);
      drive(1, 0, '0);
      rstn = 1'b0;
      #2;
      chk_reset_vals("midrst");
      tick();
      chk("midrst_hold_vld", out_vld, 0);
      rstn = 1'b1;
      tick();
      chk("rst_arm_vld", out_vld, 0);
      tick();
      chk("rst_run0_vld", out_vld, 0);
      tick();
      chk_out("rst_run1", 4, 0);
      tick();
      chk_out("rst_run2", 0, 1);

      // 12.25 over 4000 edges: total steps must be exactly 49000.
      drive(0, 1, mk(12, 16'h4000));
      tick();
      drive(1, 0, '0);
      tick();
      tick();
      sum_steps = 0;
      prev      = 0;
      bad_vld   = 0;
      bad_step  = 0;
      for (int i = 0; i < 4000; i++) begin
         tick();
         if (!out_vld) bad_vld++;
         st = int'(div_cnt) * 8 + int'(phase_sel) - prev;
         if (st != 12 && st != 13) bad_step++;
         sum_steps += st;
         prev = int'(phase_sel);
      end
      chk("frac_sum_steps", sum_steps, 49000);
      chk("frac_vld_drops", bad_vld, 0);
      chk("frac_step_range", bad_step, 0);

      // Randomized run against the reference model.
      drive(0, 0, '0);
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      model_reset();
      for (int i = 0; i < 3000; i++) begin
         r_en  = ($urandom_range(0, 19) != 0);
         r_vld = ($urandom_range(0, 3) == 0);
         r     = int'($urandom_range(0, 9));
         if (r == 0)      r_fcw = mk($urandom_range(0, MIN_STEP - 1), $urandom);
         else if (r == 1) r_fcw = mk(255, 16'hffff);
         else if (r == 2) r_fcw = mk(MIN_STEP, $urandom_range(0, 65535));
         else             r_fcw = mk($urandom_range(MIN_STEP, 255), $urandom_range(0, 65535));
         drive(r_en, r_vld, r_fcw);
         model_step(r_en, r_vld, r_fcw);
         tick();
         chk("rnd_vld", out_vld, m_vld);
         chk("rnd_rdy", cfg_rdy, model_rdy());
         chk("rnd_err", cfg_err, m_err);
         chk("rnd_oh", phase_oh, m_vld ? (8'h1 << m_sel) : 8'h0);
         if (m_vld) begin
            chk("rnd_sel", phase_sel, m_sel);
            chk("rnd_div", div_cnt, m_div);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
